qmux_seq: RTL and testbench
===========================

Name: qmux_seq

Overview:
- Parametrised successor to the two-input quad-clock mux cell.
- Selects one of N_IN fabric/global inputs onto a registered output, W bits wide.
- Source changes go through a sequenced break-before-make handshake: output forced idle for DEAD_CYCLES, then switched.
- Sits between global mux inputs and quadrant distribution in the ap3 routing primitives.

Parameters:
- N_IN, 4, number of selectable inputs (2..16).
- W, 1, width of each input channel and of IZ.
- SELW, 2, select width; must satisfy 2**SELW >= N_IN.
- DEAD_CYCLES, 2, cycles IZ is held idle during a switch (1..15).
- RST_SEL, 0, select index active after reset.

Ports:
- QCK  input  1  clock.
- QRT  input  1  reset: synchronous, active-high.
- GMUXIN  input  N_IN*W  packed inputs; channel k occupies bits [k*W +: W].
- IS  input  SELW  requested select index.
- IS_VLD  input  1  select request valid.
- IS_RDY  output  1  block can accept a request.
- IZ  output  W  registered selected channel.
- IS_CUR  output  SELW  select currently driving IZ.
- BUSY  output  1  switch sequence in progress.
- ERR  output  1  one-cycle pulse when an out-of-range request is rejected.

Behaviour:
- Reset (QRT=1 at a QCK edge) takes priority over everything:
  - IZ=0, IS_CUR=RST_SEL, BUSY=0, ERR=0, IS_RDY=1, FSM=IDLE, dead counter=0.
- Datapath: IZ <= GMUXIN[IS_CUR] every cycle in IDLE. Latency is 1 cycle from GMUXIN to IZ.
- Handshake: a request is accepted on a QCK edge with IS_VLD=1 and IS_RDY=1.
  - IS_RDY=1 only in IDLE and combinationally independent of IS_VLD.
  - IS is sampled only at acceptance.
  - IS_VLD while IS_RDY=0 is ignored, not queued.
- FSM states:
  - IDLE:
    - Accept with IS==IS_CUR: no-op. Stay in IDLE, no gap in IZ, BUSY stays 0.
    - Accept with IS>=N_IN: reject. ERR=1 for the next cycle, IS_CUR unchanged, stay in IDLE.
    - Accept with valid, different IS: latch target, load counter with DEAD_CYCLES, go to GATE. BUSY=1 from the next cycle.
  - GATE:
    - IZ <= 0 each cycle; counter decrements.
    - When counter reaches 1, go to SWITCH.
    - IZ is exactly 0 for DEAD_CYCLES consecutive cycles.
  - SWITCH (1 cycle):
    - IS_CUR <= target; IZ <= 0.
    - Go to IDLE; BUSY=0 and IS_RDY=1 on the next cycle.
    - The first IZ from the new channel appears the cycle after returning to IDLE.
- Total switch latency: acceptance edge to first new-channel IZ = DEAD_CYCLES+2 cycles.
- Back-to-back requests: a new request can be accepted in the first IDLE cycle after SWITCH.
- Reset mid-switch: abort immediately.
  - IS_CUR=RST_SEL; the pending target is discarded.
  - No ERR pulse.
- Counter width is 4 bits. A DEAD_CYCLES value outside 1..15 is an elaboration error.
- IS_CUR never takes a value >= N_IN.

Optional Feature:
- Macro: QMUX_HOLD_LAST_EN.
- Defined: in GATE and SWITCH, IZ holds its last IDLE value instead of 0. This is a hold-last dead band for level-type control signals. All timing, BUSY and IS_RDY behaviour is unchanged.
- Undefined: IZ is forced to 0 during GATE and SWITCH, as described above.

Test Plan:
- Reset and defaults: QRT=1 for 2 cycles with GMUXIN=4'b0101, W=1. After release: IS_CUR=0, IS_RDY=1, BUSY=0; IZ=1 one cycle later.
- Normal switch: IDLE with IS_CUR=0; accept IS=2, DEAD_CYCLES=2, GMUXIN=4'b0101.
  - BUSY=1 for 3 cycles; IZ=0 for 3 cycles (2 gate + 1 switch).
  - IS_CUR=2; then IZ=1 at acceptance+4.
- Same-select no-op: accept IS=IS_CUR=1 while channel 1 toggles. IZ follows with 1-cycle latency and no gap; BUSY stays 0.
- Out-of-range: N_IN=3, SELW=2; accept IS=3. ERR=1 for exactly one cycle; IS_CUR unchanged; IZ uninterrupted.
- Request while busy, and reset mid-switch:
  - During GATE, drive IS_VLD=1 with IS=3: it is ignored, and the target stays as originally requested.
  - Assert QRT in GATE: the next cycle shows IS_CUR=RST_SEL, BUSY=0, IZ=0.
- Hold-last build with QMUX_HOLD_LAST_EN defined, IZ=1 before a switch: IZ stays 1 through all gate and switch cycles, then takes the new channel value.

Source files
------------

// File: rtl/qmux_seq.sv
// rtl/qmux_seq.sv - N-input registered clock-mux cell with break-before-make source switching.
// Define QMUX_HOLD_LAST_EN to hold the last IDLE output during the dead band instead of forcing 0.
module qmux_seq #(
  parameter int N_IN        = 4,
  parameter int W           = 1,
  parameter int SELW        = 2,
  parameter int DEAD_CYCLES = 2,
  parameter int RST_SEL     = 0
) (
  input  logic                QCK,
  input  logic                QRT,
  input  logic [N_IN*W-1:0]   GMUXIN,
  input  logic [SELW-1:0]     IS,
  input  logic                IS_VLD,
  output logic                IS_RDY,
  output logic [W-1:0]        IZ,
  output logic [SELW-1:0]     IS_CUR,
  output logic                BUSY,
  output logic                ERR
);

  if (DEAD_CYCLES < 1 || DEAD_CYCLES > 15) begin : g_bad_dead_cycles
    $error("qmux_seq: DEAD_CYCLES must be in 1..15");
  end
  if (N_IN < 2 || N_IN > 16 || (2 ** SELW) < N_IN) begin : g_bad_sel
    $error("qmux_seq: N_IN must be 2..16 and fit in SELW bits");
  end
  if (RST_SEL < 0 || RST_SEL >= N_IN) begin : g_bad_rst_sel
    $error("qmux_seq: RST_SEL must be below N_IN");
  end

  localparam logic [3:0]      DC_L      = 4'(DEAD_CYCLES);
  localparam logic [SELW-1:0] RST_SEL_L = SELW'(RST_SEL);
  localparam logic [SELW:0]   N_IN_L    = (SELW + 1)'(N_IN);
`ifdef QMUX_HOLD_LAST_EN
  localparam logic HOLD_LAST = 1'b1;
`else
  localparam logic HOLD_LAST = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, GATE, SWITCH} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [SELW-1:0] target;
  logic [W-1:0]    sel_data;
  logic            in_range;

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (IS_CUR == SELW'(k)) sel_data = GMUXIN[k*W +: W];
    end
  end

  assign in_range = ({1'b0, IS} < N_IN_L);

  always_ff @(posedge QCK) begin
    if (QRT) begin
      state  <= IDLE;
      cnt    <= '0;
      target <= RST_SEL_L;
      IZ     <= '0;
      IS_CUR <= RST_SEL_L;
      BUSY   <= 1'b0;
      ERR    <= 1'b0;
      IS_RDY <= 1'b1;
    end else begin
      ERR <= 1'b0;
      case (state)
        IDLE: begin
          IZ <= sel_data;
          if (IS_VLD && IS_RDY) begin
            if (!in_range) begin
              ERR <= 1'b1;
            end else if (IS != IS_CUR) begin
              target <= IS;
              cnt    <= DC_L;
              state  <= GATE;
              BUSY   <= 1'b1;
              IS_RDY <= 1'b0;
            end
          end
        end
        GATE: begin
          IZ  <= HOLD_LAST ? IZ : '0;
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) state <= SWITCH;
        end
        SWITCH: begin
          // New source is selected here but only reaches IZ from the next IDLE cycle.
          IZ     <= HOLD_LAST ? IZ : '0;
          IS_CUR <= target;
          state  <= IDLE;
          BUSY   <= 1'b0;
          IS_RDY <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          BUSY   <= 1'b0;
          IS_RDY <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qmux_seq.sv
// tb/tb_qmux_seq.sv - bench for qmux_seq against a cycle-count reference model.
module tb_qmux_seq;
  localparam int N_IN = 3;
  localparam int W = 2;
  localparam int SELW = 2;
  localparam int DC = 2;
  localparam int RST_SEL = 0;

  logic                QCK = 1'b0;
  logic                QRT;
  logic [N_IN*W-1:0]   GMUXIN;
  logic [SELW-1:0]     IS;
  logic                IS_VLD;
  logic                IS_RDY;
  logic [W-1:0]        IZ;
  logic [SELW-1:0]     IS_CUR;
  logic                BUSY;
  logic                ERR;

  qmux_seq #(.N_IN(N_IN), .W(W), .SELW(SELW), .DEAD_CYCLES(DC), .RST_SEL(RST_SEL)) dut (
    .QCK(QCK), .QRT(QRT), .GMUXIN(GMUXIN), .IS(IS), .IS_VLD(IS_VLD), .IS_RDY(IS_RDY),
    .IZ(IZ), .IS_CUR(IS_CUR), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 QCK = ~QCK;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: m_left counts the cycles remaining until the output is released (dead band + switch).
  int           m_cur;
  int           m_tgt;
  int           m_left;
  logic [W-1:0] m_iz;
  logic         m_err;

  function automatic logic [W-1:0] chan(input logic [N_IN*W-1:0] g, input int k);
    return g[k*W +: W];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge QCK);
    if (QRT) begin
      m_cur = RST_SEL; m_left = 0; m_iz = '0; m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      if (m_left == 0) begin
        m_iz = chan(GMUXIN, m_cur);
        if (IS_VLD) begin
          if (int'(IS) >= N_IN) m_err = 1'b1;
          else if (int'(IS) != m_cur) begin
            m_tgt = int'(IS);
            m_left = DC + 1;
          end
        end
      end else begin
`ifndef QMUX_HOLD_LAST_EN
        m_iz = '0;
`endif
        m_left--;
        if (m_left == 0) m_cur = m_tgt;
      end
    end
    #1;
    chk("iz", 32'(IZ), 32'(m_iz));
    chk("is_cur", 32'(IS_CUR), 32'(m_cur));
    chk("busy", 32'(BUSY), 32'(m_left > 0));
    chk("is_rdy", 32'(IS_RDY), 32'(m_left == 0));
    chk("err", 32'(ERR), 32'(m_err));
  endtask

  task automatic req(input int s);
    IS = SELW'(s);
    IS_VLD = 1'b1;
    step();
    IS_VLD = 1'b0;
  endtask

  initial begin
    QRT = 1'b1; IS_VLD = 1'b0; IS = '0;
    GMUXIN = 6'b01_10_01;
    step(); step();
    QRT = 1'b0;
    step();
    chk("rst_is_cur", 32'(IS_CUR), 32'(RST_SEL));
    step();
    chk("rst_iz_ch0", 32'(IZ), 32'(2'b01));

    req(2);
    repeat (3) step();
    chk("sw_is_cur", 32'(IS_CUR), 32'd2);
    step();
    chk("sw_new_iz", 32'(IZ), 32'(2'b01));
    step();

    req(1);
    repeat (5) step();

    IS = 2'd1;
    for (int i = 0; i < 6; i++) begin
      GMUXIN[3:2] = 2'($urandom);
      IS_VLD = (i == 2);
      step();
    end
    IS_VLD = 1'b0;

    req(3);
    chk("oor_err", 32'(ERR), 32'd1);
    step();
    chk("oor_err_clr", 32'(ERR), 32'd0);
    step();

    req(0);
    IS = 2'd3; IS_VLD = 1'b1;
    step();
    IS = 2'd2;
    step();
    IS_VLD = 1'b0;
    repeat (4) step();
    chk("busy_ignored_tgt", 32'(IS_CUR), 32'd0);

    req(2);
    step();
    QRT = 1'b1;
    step();
    QRT = 1'b0;
    chk("midrst_busy", 32'(BUSY), 32'd0);
    chk("midrst_cur", 32'(IS_CUR), 32'(RST_SEL));
    step(); step();

    for (int i = 0; i < 400; i++) begin
      QRT = ($urandom_range(0, 63) == 0);
      IS_VLD = ($urandom_range(0, 2) == 0);
      IS = SELW'($urandom);
      GMUXIN = 6'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
